// File: rtl/leapfrog_wb_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leapfrog_wb_sched_pkg : LC-3b types, leapfrog buffer entry and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package leapfrog_wb_sched_pkg;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;

  typedef struct packed {
    lc3b_reg  dest;
    lc3b_word data;
    logic     write;
    logic     load_cc;
    lc3b_nzp  cc;
  } leapfrog_entry_t;

  typedef enum logic [1:0] {
    LF_IDLE    = 2'd0,
    LF_COLLECT = 2'd1,
    LF_DRAIN   = 2'd2
  } lf_state_t;
endpackage
`default_nettype wire

// File: rtl/leapfrog_wb_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leapfrog_wb_sched_if : stall/leapfrog/pipe inputs and writeback port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface leapfrog_wb_sched_if;
  import leapfrog_wb_sched_pkg::*;

  logic     mem_stall;
  logic     mem_done;
  logic     flush;
  logic     leap_valid;
  lc3b_reg  leap_dest;
  lc3b_word leap_data;
  logic     leap_write;
  logic     leap_load_cc;
  lc3b_nzp  leap_cc;
  logic     leap_ready;
  logic     mem_dest_overwrite;
  logic     mem_load_cc_overwrite;
  logic     pipe_wb_en;
  lc3b_reg  pipe_wb_dest;
  lc3b_word pipe_wb_data;
  logic     pipe_load_cc;
  lc3b_nzp  pipe_cc;
  logic     wb_en;
  lc3b_reg  wb_dest;
  lc3b_word wb_data;
  logic     cc_load;
  lc3b_nzp  cc_out;
  logic     drain_stall;
  logic     busy;

  modport master (
    output mem_stall, mem_done, flush, leap_valid, leap_dest, leap_data,
           leap_write, leap_load_cc, leap_cc, mem_dest_overwrite,
           mem_load_cc_overwrite, pipe_wb_en, pipe_wb_dest, pipe_wb_data,
           pipe_load_cc, pipe_cc,
    input  leap_ready, wb_en, wb_dest, wb_data, cc_load, cc_out,
           drain_stall, busy
  );

  modport slave (
    input  mem_stall, mem_done, flush, leap_valid, leap_dest, leap_data,
           leap_write, leap_load_cc, leap_cc, mem_dest_overwrite,
           mem_load_cc_overwrite, pipe_wb_en, pipe_wb_dest, pipe_wb_data,
           pipe_load_cc, pipe_cc,
    output leap_ready, wb_en, wb_dest, wb_data, cc_load, cc_out,
           drain_stall, busy
  );
endinterface
`default_nettype wire

// File: rtl/leapfrog_wb_sched_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leapfrog_fifo : circular buffer of leapfrogged results, DEPTH entries
// Rev 1.0
// ---------------------------------------------------------------------------
module leapfrog_fifo
  import leapfrog_wb_sched_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            clear,
  input  wire logic            push,
  input  wire leapfrog_entry_t push_data,
  input  wire logic            pop,
  output leapfrog_entry_t      head,
  output logic [CW-1:0]        count
);

  leapfrog_entry_t mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/leapfrog_wb_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leapfrog_wb_sched : retires stalled MEM op, then drains leapfrogged results
// Optional LEAPFROG_STATS_EN adds leap_total/stall_cycles counters.  Rev 1.0
// ---------------------------------------------------------------------------
module leapfrog_wb_sched
  import leapfrog_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  leapfrog_wb_sched_if.slave bus
`ifdef LEAPFROG_STATS_EN
  ,
  output logic [15:0]       leap_total,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  lf_state_t       state, state_next;
  logic            ovr_dest, ovr_dest_next;
  logic            ovr_cc, ovr_cc_next;
  logic            push, pop, clear;
  leapfrog_entry_t push_data, head;
  logic [CW-1:0]   count;

  assign push_data = '{dest: bus.leap_dest, data: bus.leap_data,
                       write: bus.leap_write, load_cc: bus.leap_load_cc,
                       cc: bus.leap_cc};

  leapfrog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LF_IDLE;
      ovr_dest <= 1'b0;
      ovr_cc   <= 1'b0;
    end else begin
      state    <= state_next;
      ovr_dest <= ovr_dest_next;
      ovr_cc   <= ovr_cc_next;
    end
  end

  assign bus.busy = (state != LF_IDLE);

  always_comb begin
    state_next      = state;
    ovr_dest_next   = ovr_dest;
    ovr_cc_next     = ovr_cc;
    push            = 1'b0;
    pop             = 1'b0;
    clear           = 1'b0;
    bus.leap_ready  = 1'b0;
    bus.drain_stall = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_dest     = '0;
    bus.wb_data     = '0;
    bus.cc_load     = 1'b0;
    bus.cc_out      = '0;

    if (bus.flush) begin
      clear         = 1'b1;
      ovr_dest_next = 1'b0;
      ovr_cc_next   = 1'b0;
      state_next    = LF_IDLE;
    end else begin
      case (state)
        LF_IDLE: begin
          bus.wb_en   = bus.pipe_wb_en;
          bus.wb_dest = bus.pipe_wb_dest;
          bus.wb_data = bus.pipe_wb_data;
          bus.cc_load = bus.pipe_load_cc;
          bus.cc_out  = bus.pipe_cc;
          if (bus.mem_stall) state_next = LF_COLLECT;
        end
        LF_COLLECT: begin
          bus.leap_ready = (count < CW'(DEPTH));
          push           = bus.leap_valid & bus.leap_ready;
          if (push) begin
            ovr_dest_next = ovr_dest | bus.mem_dest_overwrite;
            ovr_cc_next   = ovr_cc | bus.mem_load_cc_overwrite;
          end
          // Older write is dropped when any younger buffered op supersedes it
          if (bus.mem_done) begin
            bus.wb_en     = bus.pipe_wb_en & ~ovr_dest & ~bus.mem_dest_overwrite;
            bus.wb_dest   = bus.pipe_wb_dest;
            bus.wb_data   = bus.pipe_wb_data;
            bus.cc_load   = bus.pipe_load_cc & ~ovr_cc & ~bus.mem_load_cc_overwrite;
            bus.cc_out    = bus.pipe_cc;
            ovr_dest_next = 1'b0;
            ovr_cc_next   = 1'b0;
            state_next    = ((count != '0) || push) ? LF_DRAIN : LF_IDLE;
          end
        end
        LF_DRAIN: begin
          bus.drain_stall = 1'b1;
          bus.wb_en       = head.write;
          bus.wb_dest     = head.dest;
          bus.wb_data     = head.data;
          bus.cc_load     = head.load_cc;
          bus.cc_out      = head.cc;
          pop             = 1'b1;
          if (count <= CW'(1)) state_next = LF_IDLE;
        end
        default: state_next = LF_IDLE;
      endcase
    end
  end

`ifdef LEAPFROG_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leap_total   <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && (leap_total != 16'hFFFF)) leap_total <= leap_total + 16'd1;
      if ((state == LF_COLLECT) && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_leapfrog_wb_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_leapfrog_wb_sched : directed self-checking bench for leapfrog_wb_sched
// ---------------------------------------------------------------------------
module tb_leapfrog_wb_sched;
  import leapfrog_wb_sched_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  leapfrog_wb_sched_if bus ();

`ifdef LEAPFROG_STATS_EN
  logic [15:0] leap_total;
  logic [15:0] stall_cycles;
`endif

  leapfrog_wb_sched #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LEAPFROG_STATS_EN
    ,
    .leap_total   (leap_total),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic zero_in();
    bus.mem_stall             = 1'b0;
    bus.mem_done              = 1'b0;
    bus.flush                 = 1'b0;
    bus.leap_valid            = 1'b0;
    bus.leap_dest             = '0;
    bus.leap_data             = '0;
    bus.leap_write            = 1'b0;
    bus.leap_load_cc          = 1'b0;
    bus.leap_cc               = '0;
    bus.mem_dest_overwrite    = 1'b0;
    bus.mem_load_cc_overwrite = 1'b0;
    bus.pipe_wb_en            = 1'b0;
    bus.pipe_wb_dest          = '0;
    bus.pipe_wb_data          = '0;
    bus.pipe_load_cc          = 1'b0;
    bus.pipe_cc               = '0;
  endtask

  // Advance to just after the next rising edge and clear all inputs
  task automatic cyc();
    @(posedge clk);
    #1;
    zero_in();
  endtask

  task automatic leap(input logic [2:0] d, input logic [15:0] v, input logic w,
                      input logic lcc, input logic [2:0] cc);
    bus.leap_valid   = 1'b1;
    bus.leap_dest    = d;
    bus.leap_data    = v;
    bus.leap_write   = w;
    bus.leap_load_cc = lcc;
    bus.leap_cc      = cc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    zero_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_wb_en", bus.wb_en, 0);
    check("rst_leap_ready", bus.leap_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drain_stall", bus.drain_stall, 0);
    reset = 1'b0;

    // IDLE passthrough
    cyc();
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 3; bus.pipe_wb_data = 16'h1234;
    bus.pipe_load_cc = 1; bus.pipe_cc = 3'b010;
    #1;
    check("pt_wb_en", bus.wb_en, 1);
    check("pt_dest", bus.wb_dest, 3);
    check("pt_data", bus.wb_data, 16'h1234);
    check("pt_cc_load", bus.cc_load, 1);
    check("pt_cc_out", bus.cc_out, 3'b010);
    check("pt_busy", bus.busy, 0);

    // Two pushes, retire R4, then drain R1, R2
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(1, 16'h0005, 1, 0, 0);
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 6; bus.pipe_wb_data = 16'h9999;
    #1;
    check("col_busy", bus.busy, 1);
    check("col_ready", bus.leap_ready, 1);
    check("col_suppress", bus.wb_en, 0);
    cyc(); bus.mem_stall = 1; leap(2, 16'h0007, 1, 1, 3'b001);
    #1; check("col_ready2", bus.leap_ready, 1);
    cyc(); bus.mem_done = 1;
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 4; bus.pipe_wb_data = 16'hBEEF;
    #1;
    check("ret_wb_en", bus.wb_en, 1);
    check("ret_dest", bus.wb_dest, 4);
    check("ret_data", bus.wb_data, 16'hBEEF);
    check("ret_drain_stall", bus.drain_stall, 0);
    cyc(); #1;
    check("d1_wb_en", bus.wb_en, 1);
    check("d1_dest", bus.wb_dest, 1);
    check("d1_data", bus.wb_data, 16'h0005);
    check("d1_stall", bus.drain_stall, 1);
    check("d1_ready", bus.leap_ready, 0);
    cyc(); #1;
    check("d2_dest", bus.wb_dest, 2);
    check("d2_data", bus.wb_data, 16'h0007);
    check("d2_cc_load", bus.cc_load, 1);
    check("d2_cc_out", bus.cc_out, 3'b001);
    check("d2_stall", bus.drain_stall, 1);
    cyc(); #1;
    check("d3_busy", bus.busy, 0);
    check("d3_stall", bus.drain_stall, 0);
    check("d3_wb_en", bus.wb_en, 0);

    // Full buffer: third offer ignored, exactly two drains
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(5, 16'h0011, 1, 0, 0);
    cyc(); bus.mem_stall = 1; leap(6, 16'h0022, 1, 0, 0);
    cyc(); bus.mem_stall = 1; leap(7, 16'h0033, 1, 0, 0);
    #1; check("full_ready", bus.leap_ready, 0);
    cyc(); bus.mem_done = 1;
    #1; check("full_ret_wb_en", bus.wb_en, 0);
    cyc(); #1;
    check("full_d1_dest", bus.wb_dest, 5);
    check("full_d1_data", bus.wb_data, 16'h0011);
    cyc(); #1;
    check("full_d2_dest", bus.wb_dest, 6);
    check("full_d2_data", bus.wb_data, 16'h0022);
    cyc(); #1;
    check("full_end_busy", bus.busy, 0);
    check("full_end_wb_en", bus.wb_en, 0);

    // Dest overwrite masks the retiring write
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(3, 16'h5555, 1, 0, 0); bus.mem_dest_overwrite = 1;
    cyc(); bus.mem_done = 1;
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 3; bus.pipe_wb_data = 16'hAAAA;
    #1; check("ovr_ret_wb_en", bus.wb_en, 0);
    cyc(); #1;
    check("ovr_d1_wb_en", bus.wb_en, 1);
    check("ovr_d1_dest", bus.wb_dest, 3);
    check("ovr_d1_data", bus.wb_data, 16'h5555);

    // CC overwrite masks only CC; push on mem_done cycle drains last
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(0, 16'h0000, 0, 1, 3'b100); bus.mem_load_cc_overwrite = 1;
    cyc(); bus.mem_done = 1; leap(2, 16'h00BB, 1, 0, 0);
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 0; bus.pipe_wb_data = 16'h0001;
    bus.pipe_load_cc = 1; bus.pipe_cc = 3'b010;
    #1;
    check("ccm_ret_cc_load", bus.cc_load, 0);
    check("ccm_ret_wb_en", bus.wb_en, 1);
    cyc(); #1;
    check("ccm_d1_cc_load", bus.cc_load, 1);
    check("ccm_d1_cc_out", bus.cc_out, 3'b100);
    check("ccm_d1_wb_en", bus.wb_en, 0);
    cyc(); #1;
    check("ccm_d2_wb_en", bus.wb_en, 1);
    check("ccm_d2_dest", bus.wb_dest, 2);
    check("ccm_d2_data", bus.wb_data, 16'h00BB);

    // Flush during DRAIN with one entry left
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(1, 16'h000A, 1, 0, 0);
    cyc(); bus.mem_stall = 1; leap(2, 16'h000B, 1, 0, 0);
    cyc(); bus.mem_done = 1;
    cyc(); #1;
    check("fl_d1_data", bus.wb_data, 16'h000A);
    cyc(); bus.flush = 1;
    #1;
    check("fl_wb_en", bus.wb_en, 0);
    check("fl_drain_stall", bus.drain_stall, 0);
    cyc(); #1;
    check("fl_busy", bus.busy, 0);
    check("fl_after_wb_en", bus.wb_en, 0);

    // Async reset mid-COLLECT
    cyc(); bus.mem_stall = 1;
    cyc(); bus.mem_stall = 1; leap(4, 16'h0044, 1, 0, 0);
    #1; check("ar_pre_busy", bus.busy, 1);
    #1; reset = 1'b1;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_ready", bus.leap_ready, 0);
    check("ar_wb_en", bus.wb_en, 0);
    zero_in();
    @(posedge clk); #1; reset = 1'b0;
    bus.pipe_wb_en = 1; bus.pipe_wb_dest = 7; bus.pipe_wb_data = 16'h7777;
    #1;
    check("ar_post_pt_dest", bus.wb_dest, 7);
    check("ar_post_pt_data", bus.wb_data, 16'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/leapfrog_wb_sched.md
# leapfrog_wb_sched

Writeback scheduler for the LC-3b pipeline's leapfrog mechanism. While the MEM stage is stalled, younger ALU-class instructions may leapfrog past it. This block buffers their results, retires the stalled memory instruction first, then drains the buffered results in program order through the single register-file/CC write port. Outside a stall episode it passes normal writeback straight through.

## Interface
- DEPTH, 2, leapfrog buffer entries (1..4)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- mem_stall  in  1  MEM stage stalled on memory
- mem_done  in  1  stalled memory instruction completes; pipe_* carry it this cycle
- flush  in  1  discard all buffered state
- leap_valid  in  1  execute offers a leapfrogged result (already qualified by leapfrog_load)
- leap_dest  in  lc3b_reg  destination register
- leap_data  in  lc3b_word  result
- leap_write  in  1  result writes the register file
- leap_load_cc  in  1  result loads CC
- leap_cc  in  lc3b_nzp  CC value
- leap_ready  out  1  buffer accepts leap_valid this cycle
- mem_dest_overwrite, mem_load_cc_overwrite  in  1 each  younger instruction supersedes older write
- pipe_wb_en, pipe_wb_dest, pipe_wb_data, pipe_load_cc, pipe_cc  in  normal writeback from MEM/WB
- wb_en, wb_dest, wb_data, cc_load, cc_out  out  to register file/CC
- drain_stall  out  1  hold front end and MEM/WB while draining
- busy  out  1  state != IDLE

## Operation
- States: IDLE, COLLECT, DRAIN. Reset/flush -> IDLE, FIFO empty, sticky flags clear.
- IDLE: wb_*/cc_* = pipe_*; mem_done ignored. mem_stall=1 -> COLLECT.
- COLLECT: pipe writeback suppressed (wb_en=cc_load=0) except on mem_done. leap_ready = (count<DEPTH). Accept = leap_valid & leap_ready -> push {dest,data,write,load_cc,cc}. On accept, OR mem_dest_overwrite into sticky ovr_dest, mem_load_cc_overwrite into sticky ovr_cc.
- On mem_done in COLLECT: wb_en = pipe_wb_en & ~ovr_dest; cc_load = pipe_load_cc & ~ovr_cc; same-cycle overwrite inputs also mask. Next state DRAIN if count (including same-cycle push) > 0, else IDLE. Sticky flags clear.
- DRAIN: leap_ready=0, drain_stall=1. Outputs = FIFO head (wb_en=write, cc_load=load_cc); pop each cycle. Last pop -> IDLE.
- FIFO: circular, pointers modulo DEPTH, count 0..DEPTH. Push when full cannot occur (leap_ready=0); leap_valid while not ready is ignored.
- flush: highest priority. Buffered entries and sticky flags are dropped. Outputs are 0 that cycle. Next state IDLE.
- mem_stall falling without mem_done is a protocol error. The state is held until mem_done.

## Timing
- Reset values: all outputs 0 except leap_ready=0. busy=0, drain_stall=0.
- IDLE passthrough and mem_done retirement are combinational, 0-cycle.
- Leapfrog entry is written back N+1..N+count cycles after mem_done cycle N, one per cycle, in push order.
- Push on mem_done cycle is legal and is drained last.
- Register updates (FIFO, pointers, state, flags) on clk rising edge. reset acts immediately.

## Configuration
- LEAPFROG_STATS_EN defined: adds outputs leap_total (16b, accepted pushes) and stall_cycles (16b, cycles in COLLECT). Both saturate at 16'hFFFF, clear on reset only (not flush).
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- lc3b_types: lc3b_reg, lc3b_word, lc3b_nzp are existing. Add leapfrog_entry_t struct {dest,data,write,load_cc,cc} and lf_state_t enum.
- Sub-module leapfrog_fifo (DEPTH-parameterised push/pop/count/head). FSM and output mux live in the top.

## Test plan
- IDLE passthrough: pipe_wb_en=1, dest=R3, data=16'h1234 -> same cycle wb_en=1, R3, 16'h1234; busy=0.
- mem_stall, two pushes (R1=16'h0005, R2=16'h0007), mem_done with pipe R4=16'hBEEF -> R4 written cycle N, R1 at N+1, R2 at N+2, IDLE at N+3; drain_stall high N+1..N+2.
- Full buffer: DEPTH=2, 2 pushes -> leap_ready=0; third leap_valid not stored. After mem_done, exactly 2 drains occur.
- Overwrite: push R3 with mem_dest_overwrite=1, then mem_done pipe R3=16'hAAAA -> wb_en=0 at N. R3 leap value is written at N+1.
- CC mask: push with mem_load_cc_overwrite=1 -> cc_load=0 on mem_done cycle. The leap CC is loaded at N+1.
- flush during DRAIN with 1 entry left -> wb_en=0, next cycle IDLE, busy=0. Async reset mid-COLLECT -> outputs 0 immediately.
